ring_token_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters by circulating a one-hot priority token.
- The token is a rotating one-hot ring register: the controller/scheduler counterpart to our ring-counter datapath.
- Grants are registered and held while the owner keeps its request high. On release, the grant hands off to the next requester in ring order.
- Sits between requesting engines and a shared bus or port.

---
 rtl/ring_arb_pkg.sv | 43 ++++
 rtl/ring_token_arbiter_rr_pick.sv | 44 ++++
 rtl/ring_token_arbiter.sv | 153 +++++++++++++++
 tb/tb_ring_token_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring token arbiter: FSM states, default
// requester count, one-hot ring rotation and one-hot to binary encoding.
package ring_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int RING_ARB_N     = 4;
  localparam int RING_ARB_MAX_N = 16;

  // Rotate the low n bits of a one-hot vector left by one, bit n-1 wrapping to bit 0.
  function automatic logic [RING_ARB_MAX_N-1:0] rotl1_onehot(
    input logic [RING_ARB_MAX_N-1:0] v,
    input int                        n
  );
    logic [RING_ARB_MAX_N-1:0] r;
    r = {RING_ARB_MAX_N{1'b0}};
    for (int i = 0; i < RING_ARB_MAX_N; i++) begin
      if (i < n) begin
        r[(i + 1) % n] = v[i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [RING_ARB_MAX_N-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < RING_ARB_MAX_N; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_token_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked requester at or after the
// token position, wrapping N-1 -> 0. Winner is one-hot or zero.
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter int N = RING_ARB_N
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] token,
  input  logic [N-1:0] mask,
  output logic [N-1:0] winner,
  output logic         any
);

  logic [N-1:0] eligible_s;
  int           start_s;
  int           idx_s;

  // Search the eligible set starting at the token bit.
  always_comb begin
    eligible_s = req & ~mask;
    winner     = {N{1'b0}};
    any        = 1'b0;
    start_s    = 0;
    idx_s      = 0;
    for (int i = 0; i < N; i++) begin
      if (token[i]) begin
        start_s = i;
      end else begin
        start_s = start_s;
      end
    end
    for (int k = 0; k < N; k++) begin
      idx_s = (start_s + k) % N;
      if (!any && eligible_s[idx_s]) begin
        winner[idx_s] = 1'b1;
        any           = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token and held grants.
// Define RING_ARB_TIMEOUT_EN to pre-empt an owner after HOLD_MAX contended cycles.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = RING_ARB_N,
  parameter int IDX_W    = $clog2(N),
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     token,
  output logic             timeout
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

`ifdef RING_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  arb_state_e       state_r, state_next_s;
  logic [N-1:0]     grant_r, grant_next_s;
  logic [N-1:0]     token_r, token_next_s;
  logic             grant_valid_r;
  logic [IDX_W-1:0] grant_idx_r;
  logic             timeout_r, timeout_next_s;
  logic             new_grant_s;
  logic             owner_req_s;
  logic             others_wait_s;
  logic             preempt_s;
  logic [N-1:0]     pick_win_s;
  logic             pick_any_s;
  logic [CNT_W-1:0] hold_cnt_s;

  // The current owner is always masked; in IDLE grant_r is zero so nothing is.
  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .token  (token_r),
    .mask   (grant_r),
    .winner (pick_win_s),
    .any    (pick_any_s)
  );

  assign owner_req_s   = |(req & grant_r);
  assign others_wait_s = |(req & ~grant_r);
  assign preempt_s     = TIMEOUT_EN && owner_req_s && pick_any_s &&
                         (hold_cnt_s == CNT_W'(HOLD_MAX));

`ifdef RING_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_r;

  // Count contended cycles of the current owner, saturating at HOLD_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if (new_grant_s) begin
      hold_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == GRANT) && others_wait_s &&
                 (hold_cnt_r < CNT_W'(HOLD_MAX))) begin
      hold_cnt_r <= hold_cnt_r + CNT_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  assign hold_cnt_s = hold_cnt_r;
`else
  assign hold_cnt_s = {CNT_W{1'b0}};
`endif

  // State, grant, token and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_r       <= {N{1'b0}};
      token_r       <= N'(1);
      grant_valid_r <= 1'b0;
      grant_idx_r   <= {IDX_W{1'b0}};
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      grant_r       <= grant_next_s;
      token_r       <= token_next_s;
      grant_valid_r <= |grant_next_s;
      grant_idx_r   <= IDX_W'(onehot_to_idx(RING_ARB_MAX_N'(grant_next_s)));
      timeout_r     <= timeout_next_s;
    end
  end

  // Next-state and next-grant selection.
  always_comb begin
    state_next_s   = state_r;
    grant_next_s   = grant_r;
    token_next_s   = token_r;
    timeout_next_s = 1'b0;
    new_grant_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_next_s = GRANT;
          grant_next_s = pick_win_s;
          new_grant_s  = 1'b1;
        end else begin
          grant_next_s = {N{1'b0}};
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          if (pick_any_s) begin
            grant_next_s = pick_win_s;
            new_grant_s  = 1'b1;
          end else begin
            state_next_s = IDLE;
            grant_next_s = {N{1'b0}};
          end
        end else if (preempt_s) begin
          grant_next_s   = pick_win_s;
          new_grant_s    = 1'b1;
          timeout_next_s = 1'b1;
        end else begin
          grant_next_s = grant_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        grant_next_s = {N{1'b0}};
      end
    endcase
    // The new owner drops to lowest priority for the following arbitration.
    if (new_grant_s) begin
      token_next_s = N'(rotl1_onehot(RING_ARB_MAX_N'(grant_next_s), N));
    end else begin
      token_next_s = token_r;
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    grant       = grant_r;
    grant_valid = grant_valid_r;
    grant_idx   = grant_idx_r;
    token       = token_r;
    timeout     = timeout_r;
  end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed, table-driven bench for ring_token_arbiter (N=4, default build).
module tb_ring_token_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] token;
  logic       timeout;

  int n_cmp;
  int n_bad;

  ring_token_arbiter #(.N(4), .IDX_W(2), .HOLD_MAX(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .token       (token),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [3:0] exp_token;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic check_all(input int tag, input logic [3:0] eg, input logic [3:0] et);
    check("grant", tag, 32'(grant), 32'(eg));
    check("grant_valid", tag, 32'(grant_valid), 32'(|eg));
    check("grant_idx", tag, 32'(grant_idx), 32'(enc(eg)));
    check("token", tag, 32'(token), 32'(et));
    check("timeout", tag, 32'(timeout), 32'd0);
  endtask

  // Drive at a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic step(input logic r, input logic [3:0] q);
    reset = r;
    req   = q;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [3:0] t);
    vec_t v;
    v.rst = r; v.req = q; v.exp_grant = g; v.exp_token = t;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    req   = 4'b0000;

    // reset with all requesting, then first grant
    add(1'b1, 4'b1111, 4'b0000, 4'b0001);
    add(1'b1, 4'b1111, 4'b0000, 4'b0001);
    add(1'b0, 4'b1111, 4'b0001, 4'b0010);
    add(1'b0, 4'b1111, 4'b0001, 4'b0010);
    add(1'b0, 4'b1111, 4'b0001, 4'b0010);
    // fairness: each owner releases in turn
    add(1'b0, 4'b1110, 4'b0010, 4'b0100);
    add(1'b0, 4'b1111, 4'b0010, 4'b0100);
    add(1'b0, 4'b1111, 4'b0010, 4'b0100);
    add(1'b0, 4'b1101, 4'b0100, 4'b1000);
    add(1'b0, 4'b1111, 4'b0100, 4'b1000);
    add(1'b0, 4'b1111, 4'b0100, 4'b1000);
    add(1'b0, 4'b1011, 4'b1000, 4'b0001);
    add(1'b0, 4'b1111, 4'b1000, 4'b0001);
    add(1'b0, 4'b1111, 4'b1000, 4'b0001);
    add(1'b0, 4'b0111, 4'b0001, 4'b0010);
    // handoff without bubble, then back to idle
    add(1'b1, 4'b0000, 4'b0000, 4'b0001);
    add(1'b0, 4'b1010, 4'b0010, 4'b0100);
    add(1'b0, 4'b1000, 4'b1000, 4'b0001);
    add(1'b0, 4'b0000, 4'b0000, 4'b0001);
    add(1'b0, 4'b0000, 4'b0000, 4'b0001);
    // sole requester regranted through the wrap
    add(1'b0, 4'b0100, 4'b0100, 4'b1000);
    add(1'b0, 4'b0000, 4'b0000, 4'b1000);
    add(1'b0, 4'b0100, 4'b0100, 4'b1000);
    add(1'b0, 4'b0100, 4'b0100, 4'b1000);
    // reset while granted
    add(1'b1, 4'b0100, 4'b0000, 4'b0001);
    add(1'b0, 4'b0100, 4'b0100, 4'b1000);
    // non-owner changes ignored while owner holds
    add(1'b0, 4'b0101, 4'b0100, 4'b1000);
    add(1'b0, 4'b1111, 4'b0100, 4'b1000);
    add(1'b0, 4'b1011, 4'b1000, 4'b0001);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      check_all(i, vecs[i].exp_grant, vecs[i].exp_token);
    end

    // Contended owner without the timeout feature keeps the grant indefinitely.
    step(1'b1, 4'b0000);
    check_all(1000, 4'b0000, 4'b0001);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b0011);
      check_all(1001 + c, 4'b0001, 4'b0010);
    end
    // Release after long hold hands straight to requester 1.
    step(1'b0, 4'b0010);
    check_all(1100, 4'b0010, 4'b0100);
    step(1'b0, 4'b0000);
    check_all(1101, 4'b0000, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
